// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver for a chain of BCD counter digits.
// Digits are snapshotted at each frame boundary, so the display never tears while the counters carry.
module bcd_display_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF   = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_blank;
    // Set after any index change or while disabled; forces one dark cycle before an asserts.
    logic                    ghost;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [6:0]              seg_logic;

    assign tick = en && (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Leading-zero mask: scan from the MSD down while every digit seen so far is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (sh_digits[i*4 +: 4] == 4'd0);
            lz_mask[i] = all_zero && (i != 0);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = sh_digits[i*4 +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank && lz_mask[i];
                an_sel[i] = 1'b0;
            end
        end
        seg_logic = cur_blank ? 7'h00 : bcd_to_seg(cur_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= 1'b0;
        end else if (wrap) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_lz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghost <= 1'b1;
        end else begin
            ghost <= tick || !en;
        end
    end

    // Output stage uses the pre-edge index, so new index values show one clock after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= '1;
        end else if (!en) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= '1;
        end else begin
            seg <= seg_logic ^ {7{SEG_ACTIVE_LOW}};
            dp  <= cur_dp ^ SEG_ACTIVE_LOW;
            an  <= ghost ? '1 : an_sel;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with 4 digits, 4 clocks per slot, active-low segments.
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    logic [3:0] an_log[16];
    logic [6:0] seg_log[16];
    logic       dp_log[16];

    bcd_display_scan #(
        .NUM_DIGITS(4),
        .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp(dp),
        .an(an)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected an for cycle k of a frame: one dark cycle then three active cycles per slot.
    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] one;
        one = 4'b0001;
        if (k % 4 == 0) return 4'b1111;
        return ~(one << (k / 4));
    endfunction

    // Records 16 cycles starting at the dark cycle of slot 0; seg/dp stored as logical levels.
    task automatic capture_frame;
        for (int k = 0; k < 16; k++) begin
            an_log[k]  = an;
            seg_log[k] = ~seg;
            dp_log[k]  = ~dp;
            step(1);
        end
    endtask

    // Align to the dark cycle that starts slot 0 of a frame.
    task automatic sync_frame;
        int n;
        n = 0;
        while (an !== 4'b0111 && n < 64) begin
            step(1);
            n++;
        end
        while (an === 4'b0111 && n < 64) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL sync_frame: got an=%b after %0d cycles, required slot-3 then slot-0 boundary", an, n);
        end
    endtask

    task automatic test_reset;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(7);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (dut.idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d required 0", dut.idx); end
        checks++; if (dut.cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", dut.cnt); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(1);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL post_reset_dark: got %b required 1111", an); end
        checks++; if (seg !== 7'h40) begin errors++; $display("FAIL post_reset_seg: got %h required 40", seg); end
        step(1);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL post_reset_an: got %b required 1110", an); end
    endtask

    task automatic test_scan;
        logic [6:0] exp_seg[4];
        exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        sync_frame();
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (an_log[k] !== exp_an(k)) begin
                errors++; $display("FAIL scan_an k=%0d: got %b required %b", k, an_log[k], exp_an(k));
            end
            checks++;
            if (seg_log[k] !== exp_seg[k/4]) begin
                errors++; $display("FAIL scan_seg k=%0d: got %h required %h", k, seg_log[k], exp_seg[k/4]);
            end
            checks++;
            if (dp_log[k] !== 1'b0) begin
                errors++; $display("FAIL scan_dp k=%0d: got %b required 0", k, dp_log[k]);
            end
        end
    endtask

    task automatic test_snapshot;
        logic [6:0] old_seg[4];
        logic [6:0] new_seg[4];
        old_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        new_seg = '{7'h7F, 7'h07, 7'h7D, 7'h6D};
        digits_in = 16'h5678;
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_log[k] !== old_seg[k/4]) begin
                errors++; $display("FAIL snap_old k=%0d: got %h required %h", k, seg_log[k], old_seg[k/4]);
            end
        end
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_log[k] !== new_seg[k/4]) begin
                errors++; $display("FAIL snap_new k=%0d: got %h required %h", k, seg_log[k], new_seg[k/4]);
            end
            checks++;
            if (an_log[k] !== exp_an(k)) begin
                errors++; $display("FAIL snap_an k=%0d: got %b required %b", k, an_log[k], exp_an(k));
            end
        end
    endtask

    task automatic test_blanking;
        logic [6:0] exp_a[4];
        logic [6:0] exp_b[4];
        exp_a = '{7'h6D, 7'h66, 7'h00, 7'h00};
        exp_b = '{7'h3F, 7'h00, 7'h00, 7'h00};
        digits_in = 16'h0045;
        blank_lz  = 1'b1;
        capture_frame();
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_log[k] !== exp_a[k/4]) begin
                errors++; $display("FAIL blank45_seg k=%0d: got %h required %h", k, seg_log[k], exp_a[k/4]);
            end
            checks++;
            if (an_log[k] !== exp_an(k)) begin
                errors++; $display("FAIL blank45_an k=%0d: got %b required %b", k, an_log[k], exp_an(k));
            end
        end
        digits_in = 16'h0000;
        capture_frame();
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_log[k] !== exp_b[k/4]) begin
                errors++; $display("FAIL blank0_seg k=%0d: got %h required %h", k, seg_log[k], exp_b[k/4]);
            end
        end
    endtask

    task automatic test_invalid_dp;
        logic [6:0] exp_seg[4];
        logic       exp_dp[4];
        exp_seg = '{7'h40, 7'h3F, 7'h3F, 7'h3F};
        exp_dp  = '{1'b1, 1'b0, 1'b0, 1'b0};
        digits_in = 16'h000B;
        dp_in     = 4'b0001;
        blank_lz  = 1'b0;
        capture_frame();
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_log[k] !== exp_seg[k/4]) begin
                errors++; $display("FAIL inv_seg k=%0d: got %h required %h", k, seg_log[k], exp_seg[k/4]);
            end
            checks++;
            if (dp_log[k] !== exp_dp[k/4]) begin
                errors++; $display("FAIL inv_dp k=%0d: got %b required %b", k, dp_log[k], exp_dp[k/4]);
            end
        end
    endtask

    task automatic test_enable;
        logic [3:0] exp_an_seq[6];
        logic [6:0] exp_seg_seq[6];
        exp_an_seq  = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};
        exp_seg_seq = '{7'h40, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        step(1);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL en_pre_an: got %b required 1110", an); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL en_off_an k=%0d: got %b required 1111", k, an); end
            checks++; if (seg !== 7'h7F || dp !== 1'b1) begin
                errors++; $display("FAIL en_off_seg k=%0d: got seg=%h dp=%b required 7f/1", k, seg, dp);
            end
            checks++; if (dut.cnt !== 2'd2 || dut.idx !== 2'd0) begin
                errors++; $display("FAIL en_off_hold k=%0d: got cnt=%0d idx=%0d required 2/0", k, dut.cnt, dut.idx);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            checks++;
            if (an !== exp_an_seq[k] || !$onehot0(~an)) begin
                errors++; $display("FAIL en_resume_an k=%0d: got %b required %b", k, an, exp_an_seq[k]);
            end
            checks++;
            if (~seg !== exp_seg_seq[k]) begin
                errors++; $display("FAIL en_resume_seg k=%0d: got %h required %h", k, ~seg, exp_seg_seq[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_blanking();
        test_invalid_dp();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
